// File: rtl/shared_timer_arbiter.sv
// shared_timer_arbiter: one up-counter timer shared round-robin among NUM_REQ requesters.
module shared_timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_COUNT = 255,
  localparam int CW = $clog2(MAX_COUNT + 1),
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*CW-1:0] req_len,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  busy,
  output logic [CW-1:0]         count,
  output logic [NUM_REQ-1:0]    done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [NUM_REQ-1:0] grant_n, done_n;
  logic [CW-1:0] count_n, len, len_n, raw, clamped;
  logic [IW-1:0] last, last_n, win;
  logic any;
  // Search from last+1 upward; descending loop lets the nearest candidate win.
  always_comb begin
    win = last;
    any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_REQ]) begin
        win = IW'((int'(last) + k) % NUM_REQ);
        any = 1'b1;
      end
    end
  end
  assign raw = req_len[int'(win)*CW +: CW];
  assign clamped = (raw == '0) ? CW'(1) : (raw >= CW'(MAX_COUNT)) ? CW'(MAX_COUNT) : raw;
  always_comb begin
    state_n = state;
    grant_n = '0;
    count_n = '0;
    done_n = '0;
    len_n = len;
    last_n = last;
    case (state)
      IDLE: if (any) begin
        state_n = RUN;
        grant_n = NUM_REQ'(1) << win;
        last_n = win;
        len_n = clamped;
      end
      RUN: if (!req[last]) state_n = IDLE;
      else if (count == len - CW'(1)) begin
        state_n = DONE;
        done_n = NUM_REQ'(1) << last;
      end else begin
        grant_n = grant;
        count_n = count + CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      busy <= 1'b0;
      count <= '0;
      done <= '0;
      len <= '0;
      last <= IW'(NUM_REQ - 1);
    end else begin
      state <= state_n;
      grant <= grant_n;
      busy <= |grant_n;
      count <= count_n;
      done <= done_n;
      len <= len_n;
      last <= last_n;
    end
  end
endmodule

// File: tb/tb_shared_timer_arbiter.sv
// tb_shared_timer_arbiter: directed scoreboard bench for shared_timer_arbiter.
module tb_shared_timer_arbiter;
  localparam int N = 4;
  localparam int MC = 200;
  localparam int CW = $clog2(MC + 1);
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, grant, done;
  logic [N*CW-1:0] req_len;
  logic busy;
  logic [CW-1:0] count;
  typedef struct packed {
    logic [N-1:0] g;
    logic b;
    logic [CW-1:0] c;
    logic [N-1:0] d;
  } exp_t;
  exp_t sb[$];
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  shared_timer_arbiter #(.NUM_REQ(N), .MAX_COUNT(MC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len),
    .grant(grant), .busy(busy), .count(count), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask
  task automatic go(input logic [N-1:0] g, input logic b, input int c, input logic [N-1:0] d);
    exp_t e;
    sb.push_back('{g, b, CW'(c), d});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("grant", 32'(grant), 32'(e.g));
    chk("busy", 32'(busy), 32'(e.b));
    chk("count", 32'(count), 32'(e.c));
    chk("done", 32'(done), 32'(e.d));
  endtask
  task automatic run(input int i, input int len);
    for (int c = 0; c < len; c++) go(N'(1) << i, 1'b1, c, '0);
    go('0, 1'b0, 0, N'(1) << i);
  endtask
  task automatic setlen(input int i, input int v);
    req_len[i*CW +: CW] = CW'(v);
  endtask
  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req = '0;
    req_len = '0;
    go('0, 1'b0, 0, '0);
    rst = 1'b0;
    repeat (5) go('0, 1'b0, 0, '0);
    // single request, length change after latch must be ignored
    setlen(1, 3);
    req = 4'b0010;
    go(4'b0010, 1'b1, 0, '0);
    setlen(1, 7);
    go(4'b0010, 1'b1, 1, '0);
    go(4'b0010, 1'b1, 2, '0);
    go('0, 1'b0, 0, 4'b0010);
    req = '0;
    go('0, 1'b0, 0, '0);
    // round-robin with wrap from a fresh pointer
    rst = 1'b1;
    go('0, 1'b0, 0, '0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) setlen(i, 2);
    req = 4'b1111;
    foreach (order[k]) begin
      run(order[k], 2);
      go('0, 1'b0, 0, '0);
    end
    req = '0;
    go('0, 1'b0, 0, '0);
    // length boundaries: zero acts as one, oversize clamps to MC
    setlen(0, 0);
    req = 4'b0001;
    run(0, 1);
    req = '0;
    go('0, 1'b0, 0, '0);
    setlen(0, 250);
    req = 4'b0001;
    run(0, MC);
    req = '0;
    go('0, 1'b0, 0, '0);
    // cancel at count 4, then pending req3 granted; req3 dropped on its last cycle
    setlen(2, 10);
    setlen(3, 3);
    req = 4'b1100;
    for (int c = 0; c <= 4; c++) go(4'b0100, 1'b1, c, '0);
    req = 4'b1000;
    go('0, 1'b0, 0, '0);
    go(4'b1000, 1'b1, 0, '0);
    go(4'b1000, 1'b1, 1, '0);
    go(4'b1000, 1'b1, 2, '0);
    req = '0;
    go('0, 1'b0, 0, '0);
    go('0, 1'b0, 0, '0);
    // reset mid-grant restores pointer so requester 0 wins again
    setlen(0, 8);
    setlen(1, 3);
    req = 4'b0001;
    for (int c = 0; c <= 5; c++) go(4'b0001, 1'b1, c, '0);
    rst = 1'b1;
    req = 4'b0011;
    go('0, 1'b0, 0, '0);
    rst = 1'b0;
    run(0, 8);
    go('0, 1'b0, 0, '0);
    run(1, 3);
    req = '0;
    go('0, 1'b0, 0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
